// File: rtl/chip8_memory.sv
// CHIP-8 memory responder: 4 KB RAM with arbitrated read/write ports, a video
// read port, and an FSM that loads the hex font and clears the framebuffer.
module chip8_memory #(
    parameter logic [11:0] FONT_BASE = 12'h000,
    parameter logic [11:0] FB_BASE   = 12'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] cpu_read_address,
    output logic [7:0]  cpu_read_data,
    input  logic        cpu_write_enable,
    input  logic [11:0] cpu_write_address,
    input  logic [7:0]  cpu_write_data,
    input  logic        ppu_read_enable,
    input  logic [11:0] ppu_read_address,
    output logic [7:0]  ppu_read_data,
    input  logic        ppu_write_enable,
    input  logic [11:0] ppu_write_address,
    input  logic [7:0]  ppu_write_data,
    input  logic [7:0]  vid_address,
    output logic [7:0]  vid_data,
    input  logic        clear,
    output logic        busy
);

    typedef enum logic [1:0] {
        INIT_FONT = 2'd0,
        INIT_FB   = 2'd1,
        IDLE      = 2'd2,
        CLEAR     = 2'd3
    } state_t;

    state_t      state_r, next_state_s;
    logic [7:0]  k_r, next_k_s;
    logic        wr_en_s;
    logic [11:0] wr_addr_s;
    logic [7:0]  wr_data_s;
    logic [11:0] rd_addr_s;
    logic [11:0] vid_addr_s;
    logic [7:0]  rd_data_r;
    logic [7:0]  vid_data_r;
    logic        busy_r;
    logic [7:0]  mem [0:4095];

    // Byte idx (0..79) of the standard font: five rows per digit 0..F.
    function automatic logic [7:0] font_byte(input logic [7:0] idx);
        logic [3:0]  digit;
        logic [2:0]  row;
        logic [39:0] glyph;
        digit = 4'(idx / 8'd5);
        row   = 3'(idx % 8'd5);
        case (digit)
            4'h0:    glyph = 40'hF0_90_90_90_F0;
            4'h1:    glyph = 40'h20_60_20_20_70;
            4'h2:    glyph = 40'hF0_10_F0_80_F0;
            4'h3:    glyph = 40'hF0_10_F0_10_F0;
            4'h4:    glyph = 40'h90_90_F0_10_10;
            4'h5:    glyph = 40'hF0_80_F0_10_F0;
            4'h6:    glyph = 40'hF0_80_F0_90_F0;
            4'h7:    glyph = 40'hF0_10_20_40_40;
            4'h8:    glyph = 40'hF0_90_F0_90_F0;
            4'h9:    glyph = 40'hF0_90_F0_10_F0;
            4'hA:    glyph = 40'hF0_90_F0_90_90;
            4'hB:    glyph = 40'hE0_90_E0_90_E0;
            4'hC:    glyph = 40'hF0_80_80_80_F0;
            4'hD:    glyph = 40'hE0_90_90_90_E0;
            4'hE:    glyph = 40'hF0_80_F0_80_F0;
            4'hF:    glyph = 40'hF0_80_F0_80_80;
            default: glyph = 40'h00_00_00_00_00;
        endcase
        case (row)
            3'd0:    font_byte = glyph[39:32];
            3'd1:    font_byte = glyph[31:24];
            3'd2:    font_byte = glyph[23:16];
            3'd3:    font_byte = glyph[15:8];
            3'd4:    font_byte = glyph[7:0];
            default: font_byte = 8'h00;
        endcase
    endfunction

    // Next-state and counter logic; k restarts at zero on every state entry.
    always_comb begin
        next_state_s = state_r;
        next_k_s     = k_r + 8'd1;
        case (state_r)
            INIT_FONT: begin
                if (k_r == 8'd79) begin
                    next_state_s = INIT_FB;
                    next_k_s     = 8'd0;
                end else begin
                    next_state_s = INIT_FONT;
                end
            end
            INIT_FB, CLEAR: begin
                if (k_r == 8'd255) begin
                    next_state_s = IDLE;
                    next_k_s     = 8'd0;
                end else begin
                    next_state_s = state_r;
                end
            end
            IDLE: begin
                next_k_s = 8'd0;
                if (clear) begin
                    next_state_s = CLEAR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = INIT_FONT;
                next_k_s     = 8'd0;
            end
        endcase
    end

    // Write-port arbitration: FSM over PPU over CPU; requester writes only in IDLE.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = 12'h000;
        wr_data_s = 8'h00;
        case (state_r)
            INIT_FONT: begin
                wr_en_s   = 1'b1;
                wr_addr_s = FONT_BASE + {4'h0, k_r};
                wr_data_s = font_byte(k_r);
            end
            INIT_FB, CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = FB_BASE + {4'h0, k_r};
                wr_data_s = 8'h00;
            end
            IDLE: begin
                if (ppu_write_enable) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = ppu_write_address;
                    wr_data_s = ppu_write_data;
                end else if (cpu_write_enable) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cpu_write_address;
                    wr_data_s = cpu_write_data;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: wr_en_s = 1'b0;
        endcase
    end

    assign rd_addr_s  = ppu_read_enable ? ppu_read_address : cpu_read_address;
    assign vid_addr_s = FB_BASE + {4'h0, vid_address};

    // FSM state, counter and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= INIT_FONT;
            k_r     <= 8'd0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= next_state_s;
            k_r     <= next_k_s;
            busy_r  <= (next_state_s != IDLE);
        end
    end

    // RAM write port; contents are left untouched while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered reads; they sample the RAM before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r  <= 8'h00;
            vid_data_r <= 8'h00;
        end else begin
            rd_data_r  <= mem[rd_addr_s];
            vid_data_r <= mem[vid_addr_s];
        end
    end

    assign cpu_read_data = rd_data_r;
    assign ppu_read_data = rd_data_r;
    assign vid_data      = vid_data_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_chip8_memory.sv
// Directed self-checking bench for chip8_memory: init, arbitration, clear,
// reset during clear and read-before-write behaviour.
module tb_chip8_memory;

    logic        clk;
    logic        reset;
    logic [11:0] cpu_read_address;
    logic [7:0]  cpu_read_data;
    logic        cpu_write_enable;
    logic [11:0] cpu_write_address;
    logic [7:0]  cpu_write_data;
    logic        ppu_read_enable;
    logic [11:0] ppu_read_address;
    logic [7:0]  ppu_read_data;
    logic        ppu_write_enable;
    logic [11:0] ppu_write_address;
    logic [7:0]  ppu_write_data;
    logic [7:0]  vid_address;
    logic [7:0]  vid_data;
    logic        clear;
    logic        busy;

    int errors = 0;
    int checks = 0;

    chip8_memory dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_read_address  (cpu_read_address),
        .cpu_read_data     (cpu_read_data),
        .cpu_write_enable  (cpu_write_enable),
        .cpu_write_address (cpu_write_address),
        .cpu_write_data    (cpu_write_data),
        .ppu_read_enable   (ppu_read_enable),
        .ppu_read_address  (ppu_read_address),
        .ppu_read_data     (ppu_read_data),
        .ppu_write_enable  (ppu_write_enable),
        .ppu_write_address (ppu_write_address),
        .ppu_write_data    (ppu_write_data),
        .vid_address       (vid_address),
        .vid_data          (vid_data),
        .clear             (clear),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cpu_rd(input logic [11:0] addr, input logic [7:0] expected, input string tag);
        cpu_read_address = addr;
        step();
        check(tag, cpu_read_data, expected);
    endtask

    task automatic vid_rd(input logic [7:0] off, input logic [7:0] expected, input string tag);
        vid_address = off;
        step();
        check(tag, vid_data, expected);
    endtask

    task automatic cpu_wr(input logic [11:0] addr, input logic [7:0] data);
        cpu_write_enable  = 1'b1;
        cpu_write_address = addr;
        cpu_write_data    = data;
        step();
        cpu_write_enable  = 1'b0;
    endtask

    // Release reset at a falling edge and check busy falls exactly 336 edges later.
    task automatic release_and_wait_init(input string tag);
        reset = 1'b0;
        repeat (335) @(posedge clk);
        @(negedge clk);
        check({tag, "_busy_335"}, {7'd0, busy}, 8'h01);
        step();
        check({tag, "_busy_336"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        logic [7:0] font_lo [0:4];
        logic [7:0] font_hi [0:4];
        font_lo = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
        font_hi = '{8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80};

        reset             = 1'b1;
        cpu_read_address  = 12'h000;
        cpu_write_enable  = 1'b0;
        cpu_write_address = 12'h000;
        cpu_write_data    = 8'h00;
        ppu_read_enable   = 1'b0;
        ppu_read_address  = 12'h000;
        ppu_write_enable  = 1'b0;
        ppu_write_address = 12'h000;
        ppu_write_data    = 8'h00;
        vid_address       = 8'h00;
        clear             = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {7'd0, busy}, 8'h01);
        check("rst_cpu_data", cpu_read_data, 8'h00);
        check("rst_ppu_data", ppu_read_data, 8'h00);
        check("rst_vid_data", vid_data, 8'h00);

        // Init sequence and font / framebuffer contents
        release_and_wait_init("init");
        for (int i = 0; i < 5; i++) cpu_rd(12'h000 + 12'(i), font_lo[i], "font_0");
        for (int i = 0; i < 5; i++) cpu_rd(12'h04B + 12'(i), font_hi[i], "font_F");
        cpu_rd(12'h005, 8'h20, "font_1_row0");
        for (int i = 0; i < 256; i++) cpu_rd(12'h100 + 12'(i), 8'h00, "init_fb");

        // CPU write then read with one-cycle latency
        cpu_wr(12'h200, 8'hAB);
        cpu_rd(12'h200, 8'hAB, "cpu_wr_rd");

        // PPU beats CPU on a same-cycle write; shared read port and video port
        cpu_write_enable  = 1'b1;
        cpu_write_address = 12'h150;
        cpu_write_data    = 8'h11;
        ppu_write_enable  = 1'b1;
        ppu_write_address = 12'h150;
        ppu_write_data    = 8'h22;
        step();
        cpu_write_enable  = 1'b0;
        ppu_write_enable  = 1'b0;
        ppu_read_enable   = 1'b1;
        ppu_read_address  = 12'h150;
        cpu_read_address  = 12'h200;
        vid_address       = 8'h50;
        step();
        check("arb_cpu_data", cpu_read_data, 8'h22);
        check("arb_ppu_data", ppu_read_data, 8'h22);
        check("arb_vid_data", vid_data, 8'h22);
        ppu_read_enable = 1'b0;
        cpu_rd(12'h200, 8'hAB, "mux_back_cpu");

        // Fill framebuffer, then clear with a dropped CPU write
        cpu_wr(12'h300, 8'h12);
        for (int i = 0; i < 256; i++) cpu_wr(12'h100 + 12'(i), 8'hFF);
        vid_rd(8'h00, 8'hFF, "fill_first");
        vid_rd(8'hFF, 8'hFF, "fill_last");
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy_rise", {7'd0, busy}, 8'h01);
        cpu_wr(12'h300, 8'h55);
        repeat (254) @(posedge clk);
        @(negedge clk);
        check("clr_busy_255", {7'd0, busy}, 8'h01);
        step();
        check("clr_busy_256", {7'd0, busy}, 8'h00);
        cpu_rd(12'h300, 8'h12, "clr_drop_write");
        for (int i = 0; i < 256; i++) vid_rd(8'(i), 8'h00, "clr_fb");

        // Reset in the middle of a clear restarts the full init
        cpu_wr(12'h000, 8'h00);
        cpu_wr(12'h1F0, 8'h5A);
        cpu_rd(12'h000, 8'h00, "font_corrupt");
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("mid_rst_busy", {7'd0, busy}, 8'h01);
        check("mid_rst_data", cpu_read_data, 8'h00);
        release_and_wait_init("reinit");
        cpu_rd(12'h000, 8'hF0, "font_rewritten");
        cpu_rd(12'h04F, 8'h80, "font_last");
        vid_rd(8'hF0, 8'h00, "reinit_fb");
        cpu_rd(12'h300, 8'h12, "ram_kept");

        // Read-before-write on both the shared and the video port
        cpu_wr(12'h120, 8'h77);
        cpu_write_enable  = 1'b1;
        cpu_write_address = 12'h120;
        cpu_write_data    = 8'h99;
        cpu_read_address  = 12'h120;
        vid_address       = 8'h20;
        step();
        cpu_write_enable = 1'b0;
        check("rbw_old_cpu", cpu_read_data, 8'h77);
        check("rbw_old_vid", vid_data, 8'h77);
        step();
        check("rbw_new_cpu", cpu_read_data, 8'h99);
        check("rbw_new_vid", vid_data, 8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
